demux2_buf: RTL and testbench

DEMUX2_BUF -- requirements
Module: demux2_buf

---
 rtl/demux2_buf.sv | 88 ++++++++
 tb/tb_demux2_buf.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/demux2_buf.sv
// rtl/demux2_buf.sv - 1:2 demultiplexer into two independent output FIFOs
//
// Purpose: routes each accepted input word into one of two DEPTH-entry FIFOs
// chosen by in_sel (1 -> channel 0, 0 -> channel 1). Each channel drains on
// its own valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_data/in_sel/in_valid word offered, route select, offer qualifier
//   in_ready                selected channel has space
//   outN_data/outN_valid    head word of channel N (0 while empty)
//   outN_ready              consumer takes head of channel N
//   cnt0, cnt1              per-channel occupancy
module demux2_buf #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [31:0]   out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic [1:0]          full;
  logic [1:0]          valid;
  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0][31:0]    head;
  logic [1:0][CW-1:0]  cnt_p;

  // Gating with rst_n keeps in_ready low while reset is held even though the
  // (cleared) counters would otherwise report free space.
  assign in_ready = rst_n & (in_sel ? ~full[0] : ~full[1]);

  assign push[0] = in_valid & in_ready & in_sel;
  assign push[1] = in_valid & in_ready & ~in_sel;
  assign pop[0]  = valid[0] & out0_ready;
  assign pop[1]  = valid[1] & out1_ready;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[g]) wptr <= wptr + PW'(1);
        if (pop[g])  rptr <= rptr + PW'(1);
        cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
      end
    end

    // Storage is unobservable while empty, so it carries no reset.
    always_ff @(posedge clk) begin
      if (push[g]) mem[wptr] <= in_data;
    end

    assign full[g]  = (cnt == CW'(DEPTH));
    assign valid[g] = (cnt != '0);
    assign head[g]  = valid[g] ? mem[rptr] : 32'h0;
    assign cnt_p[g] = cnt;
  end

  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign cnt0       = cnt_p[0];
  assign cnt1       = cnt_p[1];

endmodule

// File: tb/tb_demux2_buf.sv
// tb/tb_demux2_buf.sv - self-checking bench for demux2_buf
module tb_demux2_buf;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [31:0]   out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int passed = 0;
  int total  = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  demux2_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: two unbounded queues limited to DEPTH entries by the accept rule.
  task automatic check_outputs(input logic exp_rdy);
    check("in_ready",   32'(in_ready),   32'(exp_rdy));
    check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    check("out0_data",  out0_data,       (q0.size() != 0) ? q0[0] : 32'h0);
    check("cnt0",       32'(cnt0),       32'(q0.size()));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    check("out1_data",  out1_data,       (q1.size() != 0) ? q1[0] : 32'h0);
    check("cnt1",       32'(cnt1),       32'(q1.size()));
  endtask

  // Drive one cycle's inputs after a falling edge, check, then advance the model.
  task automatic step(input logic sel, input logic vld, input logic [31:0] d,
                      input logic r0, input logic r1);
    logic exp_rdy;
    in_sel = sel; in_valid = vld; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    exp_rdy = ((sel ? q0.size() : q1.size()) < DEPTH);
    check_outputs(exp_rdy);
    @(posedge clk);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (vld && exp_rdy) begin
      if (sel) q0.push_back(d);
      else     q1.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: ready immediately, nothing visible.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Single route to channel 0.
    step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Fill and backpressure on channel 0; popping a full channel keeps in_ready low.
    step(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Cross-channel stall: channel 1 full blocks sel=0 only.
    step(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h12, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h13, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Simultaneous push and pop on channel 1.
    step(1'b0, 1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hB, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Pointer wrap: stream 0..19 through channel 0, both channels popping.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'(i), 1'b1, 1'b1);
    for (int i = 0; i < 2; i++)  step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset mid-stream: cnt0=2, cnt1=1, then reset asserted between edges.
    step(1'b1, 1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h23, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    check("pre_rst_cnt0", 32'(cnt0), 32'd2);
    check("pre_rst_cnt1", 32'(cnt1), 32'd1);
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'(i), 1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
